fetch_unit: RTL



---
 rtl/core_pkg.sv | 16 +
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit_pc_reg.sv | 32 +++
 rtl/fetch_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package core_pkg;

    localparam int                   CORE_XLEN     = 32;
    localparam logic [CORE_XLEN-1:0] CORE_RESET_PC = 32'h0000_0000;
    localparam logic [31:0]          NOP_INSTR     = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus: req/ready acceptance, rvalid-qualified data.
interface fetch_unit_if #(
    parameter int XLEN = 32
);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Resettable program counter with load enable; loaded values are word-aligned.
module pc_reg
    import core_pkg::*;
#(
    parameter int              XLEN     = CORE_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = CORE_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [XLEN-1:0] pc_d_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d      = pc_d_i;
            pc_d[1:0] = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches one word per instruction and holds it until retire.
// Optional macro FETCH_MISALIGN_CHECK_EN halts on a misaligned retire target.
module fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = CORE_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = CORE_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_unit_if.master    imem,
    input  logic            retire,
    input  logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [31:0]     instr,
    output logic            instr_valid
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            fetch_misaligned
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic         pc_load;
    logic         req;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic         misalign_q, misalign_d;
`endif

    pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (pc_load),
        .pc_d_i (pc_next),
        .pc_o   (pc)
    );

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        pc_load       = 1'b0;
        req           = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_d    = misalign_q;
`endif
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                req = 1'b1;
                if (imem.imem_ready) state_d = WAIT;
            end
            // a retire arriving here is dropped; only rvalid matters
            WAIT: begin
                if (imem.imem_rvalid) begin
                    instr_d       = imem.imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (retire) begin
                    instr_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (pc_next[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        pc_load = 1'b1;
                        state_d = REQ;
                    end
`else
                    pc_load = 1'b1;
                    state_d = REQ;
`endif
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end
    assign fetch_misaligned = misalign_q;
`endif

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;
    assign pc_plus4       = pc + XLEN'(4);
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_q;

endmodule
